fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the segmented RV32I core: owns the PC register, drives the combinational
//  instruction memory and loads the IF/ID pipeline register consumed by decode.
//  Takes redirects from the EX-stage branch unit, and stall/flush from the hazard unit.
//  Halts fetch on EBREAK or on a misaligned redirect target.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INST   32'h0000_0013  bubble encoding (addi x0,x0,0) placed in IF/ID
//  EBREAK     32'h0010_0073  encoding that halts fetch
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  imem_addr    out  32  fetch address to InstructionMemory; equals PC register
//  imem_inst    in   32  instruction returned combinationally for imem_addr
//  stall        in   1   hold PC and IF/ID (load-use hazard)
//  flush        in   1   insert bubble into IF/ID; PC holds
//  redirect     in   1   taken branch/jump resolved in EX (NextPCSrc)
//  redirect_pc  in   32  target address (ALU result)
//  resume       in   1   leave HALT; clears misalign_err
//  if_id_valid  out  1   IF/ID holds a real instruction
//  if_id_pc     out  32  PC of the IF/ID instruction
//  if_id_pc4    out  32  PC+4 of the IF/ID instruction (link value)
//  if_id_inst   out  32  instruction word (NOP_INST when invalid)
//  halted       out  1   FSM in HALT
//  misalign_err out  1   sticky: redirect target had [1:0]!=0
//  fetch_count  out  32  valid instructions loaded into IF/ID; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (async, immediate): state=BOOT, PC=RESET_PC, if_id_valid=0, if_id_inst=NOP_INST,
//   if_id_pc=0, if_id_pc4=0, halted=0, misalign_err=0, fetch_count=0.
//  FSM BOOT -> RUN unconditionally on the first edge after reset release; IF/ID stays bubble.
//  RUN, per edge, priority redirect > flush > stall > normal:
//   redirect, target[1:0]==0: PC<=redirect_pc; IF/ID<=bubble (wrong-path kill).
//   redirect, target[1:0]!=0: PC holds; IF/ID<=bubble; misalign_err<=1; ->HALT.
//   flush: IF/ID<=bubble; PC holds (same address refetched).
//   stall: PC, IF/ID, fetch_count all hold.
//   normal: IF/ID<={1,PC,PC+4,imem_inst}; PC<=PC+4 (32-bit, wraps); fetch_count++.
//   normal with imem_inst==EBREAK: EBREAK loaded as valid; PC<=PC+4; ->HALT.
//  HALT: PC holds; IF/ID<=bubble each edge; fetch_count holds.
//   redirect, aligned target: PC<=redirect_pc; ->RUN (halting EBREAK was wrong-path).
//   redirect, misaligned target: stays HALT; misalign_err<=1.
//   resume without redirect: ->RUN; misalign_err<=0.
//   resume with redirect: the redirect rule applies; misalign_err<=0 unless this target is misaligned.
//  Latency: imem_inst at PC in cycle N appears on if_id_* after edge N+1.
//  stall/flush in BOOT: ignored. Bubble = valid 0, inst NOP_INST, pc/pc4 unchanged.
//  halted = (state==HALT), registered state, no combinational path from inputs.
// STRUCTURE
//  riscv_pipe_pkg: typedef enum logic [1:0] {BOOT,RUN,HALT} fetch_state_t;
//   typedef struct packed {valid,pc,pc4,inst} if_id_t; NOP_INST and EBREAK localparams.
//  Sub-module if_id_reg: if_id_t register with async reset, hold (stall) and bubble (kill)
//   inputs. It is reused for the ID/EX and later pipeline registers.
//  The FSM, PC register, redirect alignment check and counter live in fetch_stage.
// TESTING
//  Reset release, imem returns addi at 0,4,8 -> if_id_pc 0,4,8 on consecutive edges; fetch_count=3.
//  stall high 2 cycles at PC=8 -> if_id_* and imem_addr frozen; count unchanged; resumes at 8.
//  redirect with redirect_pc=0x40 together with stall -> next edge PC=0x40, if_id_valid=0.
//  imem_inst=EBREAK at 0x10 -> if_id_inst=EBREAK, valid=1; next edge halted=1; imem_addr=0x14, bubbles.
//  HALT plus redirect to 0x20 -> halted=0, PC=0x20; flush alone -> bubble, PC unchanged.
//  redirect_pc=0x22 -> misalign_err=1, halted=1; resume -> both 0; rst mid-run -> PC=RESET_PC at once.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and encodings for the segmented RV32I pipeline.
// Imported by the fetch stage and by every pipeline register built from if_id_reg.
package riscv_pipe_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
   } if_id_t;

   localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, inst: NOP_INST};

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying one if_id_t slot; kill inserts a bubble, hold freezes it.
// Kill wins over hold so a squashed slot never survives a stall.
import riscv_pipe_pkg::*;

module if_id_reg (
   input  logic   clk,
   input  logic   rst,
   input  logic   hold,
   input  logic   kill,
   input  if_id_t d,
   output if_id_t q
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= IF_ID_RESET;
      end else if (kill) begin
         q.valid <= 1'b0;
         q.inst  <= NOP_INST;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, BOOT/RUN/HALT fetch FSM, redirect alignment check and fetch counter.
// Loads the IF/ID register; instruction memory is combinational on imem_addr.
import riscv_pipe_pkg::*;

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        resume,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic [31:0] if_id_inst,
   output logic        halted,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   fetch_state_t state, nextState;
   logic [31:0]  pcReg, pcNext, pcPlus4, countReg;
   logic         misalignReg, misalignNext;
   logic         ifIdKill, ifIdHold, countInc, targetAligned;
   if_id_t       ifIdD, ifIdQ;

   assign pcPlus4       = pcReg + 32'd4;
   assign targetAligned = (redirect_pc[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= BOOT;
         pcReg       <= RESET_PC;
         countReg    <= 32'h0;
         misalignReg <= 1'b0;
      end else begin
         state       <= nextState;
         pcReg       <= pcNext;
         misalignReg <= misalignNext;
         if (countInc) countReg <= countReg + 32'd1;
      end
   end

   // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      nextState = state;
      case (state)
         BOOT: nextState = RUN;
         RUN: begin
            if (redirect)                   nextState = targetAligned ? RUN : HALT;
            else if (flush || stall)        nextState = RUN;
            else if (imem_inst == EBREAK)   nextState = HALT;
         end
         HALT: begin
            if (redirect)    nextState = targetAligned ? RUN : HALT;
            else if (resume) nextState = RUN;
         end
         default: nextState = BOOT;
      endcase
   end

   always_comb begin
      pcNext       = pcReg;
      misalignNext = misalignReg;
      ifIdKill     = 1'b0;
      ifIdHold     = 1'b0;
      countInc     = 1'b0;
      case (state)
         RUN: begin
            if (redirect) begin
               ifIdKill = 1'b1;
               if (targetAligned) pcNext = redirect_pc;
               else               misalignNext = 1'b1;
            end else if (flush) begin
               ifIdKill = 1'b1;
            end else if (stall) begin
               ifIdHold = 1'b1;
            end else begin
               pcNext   = pcPlus4;
               countInc = 1'b1;
            end
         end
         HALT: begin
            ifIdKill = 1'b1;
            if (resume) misalignNext = 1'b0;
            if (redirect) begin
               if (targetAligned) pcNext = redirect_pc;
               else               misalignNext = 1'b1;
            end
         end
         default: ifIdKill = 1'b1;
      endcase
   end

   assign ifIdD = '{valid: 1'b1, pc: pcReg, pc4: pcPlus4, inst: imem_inst};

   if_id_reg uIfIdReg (
      .clk  (clk),
      .rst  (rst),
      .hold (ifIdHold),
      .kill (ifIdKill),
      .d    (ifIdD),
      .q    (ifIdQ)
   );

   assign imem_addr    = pcReg;
   assign if_id_valid  = ifIdQ.valid;
   assign if_id_pc     = ifIdQ.pc;
   assign if_id_pc4    = ifIdQ.pc4;
   assign if_id_inst   = ifIdQ.inst;
   assign halted       = (state == HALT);
   assign misalign_err = misalignReg;
   assign fetch_count  = countReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns "addi x1,x0,addr" except EBREAK at ebreakAddr.
// Each step advances one rising edge and checks the registered outputs 1 ns later.
import riscv_pipe_pkg::*;

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imemAddr, imemInst;
   logic        stall, flush, redirect, resume;
   logic [31:0] redirectPc;
   logic        ifIdValid, halted, misalignErr;
   logic [31:0] ifIdPc, ifIdPc4, ifIdInst, fetchCount;
   logic [31:0] ebreakAddr;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   always_comb imemInst = (imemAddr == ebreakAddr) ? EBREAK
                                                   : (32'h0000_0093 | {imemAddr[11:0], 20'h0});

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .imem_addr    (imemAddr),
      .imem_inst    (imemInst),
      .stall        (stall),
      .flush        (flush),
      .redirect     (redirect),
      .redirect_pc  (redirectPc),
      .resume       (resume),
      .if_id_valid  (ifIdValid),
      .if_id_pc     (ifIdPc),
      .if_id_pc4    (ifIdPc4),
      .if_id_inst   (ifIdInst),
      .halted       (halted),
      .misalign_err (misalignErr),
      .fetch_count  (fetchCount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc, input logic [31:0] pc4,
                               input logic [31:0] inst, input logic [31:0] count,
                               input logic hlt, input logic mis);
      check({tag, ".imem_addr"}, imemAddr, addr);
      check({tag, ".valid"}, {31'h0, ifIdValid}, {31'h0, valid});
      check({tag, ".pc"}, ifIdPc, pc);
      check({tag, ".pc4"}, ifIdPc4, pc4);
      check({tag, ".inst"}, ifIdInst, inst);
      check({tag, ".count"}, fetchCount, count);
      check({tag, ".halted"}, {31'h0, halted}, {31'h0, hlt});
      check({tag, ".misalign"}, {31'h0, misalignErr}, {31'h0, mis});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; resume = 1'b0;
      redirectPc = 32'h0; ebreakAddr = 32'hFFFF_FFF0;
      #2;
      expect_state("reset", 32'h0, 1'b0, 32'h0, 32'h0, NOP_INST, 32'd0, 1'b0, 1'b0);

      @(negedge clk); rst = 1'b0;
      step(); expect_state("boot", 32'h0, 1'b0, 32'h0, 32'h0, NOP_INST, 32'd0, 1'b0, 1'b0);
      step(); expect_state("fetch0", 32'h4, 1'b1, 32'h0, 32'h4, 32'h0000_0093, 32'd1, 1'b0, 1'b0);
      step(); expect_state("fetch4", 32'h8, 1'b1, 32'h4, 32'h8, 32'h0040_0093, 32'd2, 1'b0, 1'b0);

      stall = 1'b1;
      step(); expect_state("stall1", 32'h8, 1'b1, 32'h4, 32'h8, 32'h0040_0093, 32'd2, 1'b0, 1'b0);
      step(); expect_state("stall2", 32'h8, 1'b1, 32'h4, 32'h8, 32'h0040_0093, 32'd2, 1'b0, 1'b0);
      stall = 1'b0;
      step(); expect_state("fetch8", 32'hC, 1'b1, 32'h8, 32'hC, 32'h0080_0093, 32'd3, 1'b0, 1'b0);

      stall = 1'b1; redirect = 1'b1; redirectPc = 32'h40;
      step(); expect_state("redir_stall", 32'h40, 1'b0, 32'h8, 32'hC, NOP_INST, 32'd3, 1'b0, 1'b0);
      stall = 1'b0; redirect = 1'b0;
      step(); expect_state("fetch40", 32'h44, 1'b1, 32'h40, 32'h44, 32'h0400_0093, 32'd4, 1'b0, 1'b0);

      redirect = 1'b1; redirectPc = 32'h10; ebreakAddr = 32'h10;
      step(); expect_state("redir10", 32'h10, 1'b0, 32'h40, 32'h44, NOP_INST, 32'd4, 1'b0, 1'b0);
      redirect = 1'b0;
      step(); expect_state("ebreak", 32'h14, 1'b1, 32'h10, 32'h14, EBREAK, 32'd5, 1'b1, 1'b0);
      step(); expect_state("halt_bub", 32'h14, 1'b0, 32'h10, 32'h14, NOP_INST, 32'd5, 1'b1, 1'b0);

      redirect = 1'b1; redirectPc = 32'h20;
      step(); expect_state("halt_redir", 32'h20, 1'b0, 32'h10, 32'h14, NOP_INST, 32'd5, 1'b0, 1'b0);
      redirect = 1'b0; flush = 1'b1;
      step(); expect_state("flush", 32'h20, 1'b0, 32'h10, 32'h14, NOP_INST, 32'd5, 1'b0, 1'b0);
      flush = 1'b0;
      step(); expect_state("fetch20", 32'h24, 1'b1, 32'h20, 32'h24, 32'h0200_0093, 32'd6, 1'b0, 1'b0);

      redirect = 1'b1; redirectPc = 32'h22;
      step(); expect_state("misalign", 32'h24, 1'b0, 32'h20, 32'h24, NOP_INST, 32'd6, 1'b1, 1'b1);
      redirect = 1'b0;
      step(); expect_state("mis_hold", 32'h24, 1'b0, 32'h20, 32'h24, NOP_INST, 32'd6, 1'b1, 1'b1);
      resume = 1'b1;
      step(); expect_state("resume", 32'h24, 1'b0, 32'h20, 32'h24, NOP_INST, 32'd6, 1'b0, 1'b0);
      resume = 1'b0;
      step(); expect_state("fetch24", 32'h28, 1'b1, 32'h24, 32'h28, 32'h0240_0093, 32'd7, 1'b0, 1'b0);

      redirect = 1'b1; redirectPc = 32'h22;
      step(); expect_state("misalign2", 32'h28, 1'b0, 32'h24, 32'h28, NOP_INST, 32'd7, 1'b1, 1'b1);
      redirect = 1'b1; redirectPc = 32'h30; resume = 1'b1;
      step(); expect_state("res_redir", 32'h30, 1'b0, 32'h24, 32'h28, NOP_INST, 32'd7, 1'b0, 1'b0);
      redirect = 1'b0; resume = 1'b0;
      step(); expect_state("fetch30", 32'h34, 1'b1, 32'h30, 32'h34, 32'h0300_0093, 32'd8, 1'b0, 1'b0);

      #2; rst = 1'b1;
      #1; expect_state("mid_reset", 32'h0, 1'b0, 32'h0, 32'h0, NOP_INST, 32'd0, 1'b0, 1'b0);
      stall = 1'b1; flush = 1'b1;
      @(negedge clk); rst = 1'b0;
      step(); expect_state("boot2", 32'h0, 1'b0, 32'h0, 32'h0, NOP_INST, 32'd0, 1'b0, 1'b0);
      stall = 1'b0; flush = 1'b0;
      step(); expect_state("refetch0", 32'h4, 1'b1, 32'h0, 32'h4, 32'h0000_0093, 32'd1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
